// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the functional-unit result handshake and the Common Data Bus
// broadcast of cdb_arbiter.
//   fu_valid   [NUM_FU]            result valid per FU
//   fu_rob_tag [NUM_FU*ROB_TAG_W]  destination ROB tag, FU i in slice i
//   fu_value   [NUM_FU*XLEN]       result value, FU i in slice i
//   fu_ready   [NUM_FU]            per-FU buffer can accept
//   cdb_valid / cdb_rob_tag / cdb_value / cdb_fu_idx : registered broadcast
// Modports: master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_FU    = 5,
  parameter int unsigned ROB_TAG_W = 5,
  parameter int unsigned XLEN      = 32
);
  localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag;
  logic [NUM_FU*XLEN-1:0]      fu_value;
  logic [NUM_FU-1:0]           fu_ready;
  logic                        cdb_valid;
  logic [ROB_TAG_W-1:0]        cdb_rob_tag;
  logic [XLEN-1:0]             cdb_value;
  logic [IdxW-1:0]             cdb_fu_idx;

  modport master (
    output fu_valid, fu_rob_tag, fu_value,
    input  fu_ready, cdb_valid, cdb_rob_tag, cdb_value, cdb_fu_idx
  );

  modport slave (
    input  fu_valid, fu_rob_tag, fu_value,
    output fu_ready, cdb_valid, cdb_rob_tag, cdb_value, cdb_fu_idx
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU skid FIFOs feeding a round-robin arbiter that drives one registered
// Common Data Bus broadcast per cycle.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   squash        : synchronous flush of all buffers, pointer and broadcast
//   bus (slave)   : FU result handshake in, CDB broadcast out (see cdb_arbiter_if)
// Optional: define CDB_STATS_EN to add saturating 32-bit counters
//   stat_broadcasts   : cycles in which a valid broadcast is loaded
//   stat_stall_cycles : cycles with any FU valid while its buffer is full
module cdb_arbiter #(
  parameter int unsigned NUM_FU     = 5,
  parameter int unsigned ROB_TAG_W  = 5,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]  stat_broadcasts,
  output logic [31:0]  stat_stall_cycles
`endif
);

  localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  logic [ROB_TAG_W-1:0] tag_mem_q [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]      val_mem_q [NUM_FU][FIFO_DEPTH];

  logic [PtrW-1:0] head_q  [NUM_FU];
  logic [PtrW-1:0] head_d  [NUM_FU];
  logic [PtrW-1:0] tail_q  [NUM_FU];
  logic [PtrW-1:0] tail_d  [NUM_FU];
  logic [CntW-1:0] count_q [NUM_FU];
  logic [CntW-1:0] count_d [NUM_FU];

  logic [IdxW-1:0]      rr_q, rr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]      cdb_value_q, cdb_value_d;
  logic [IdxW-1:0]      cdb_idx_q, cdb_idx_d;

  logic [NUM_FU-1:0]    ready, push, pop, nonempty;
  logic                 found;
  logic [IdxW-1:0]      win;
  logic [ROB_TAG_W-1:0] win_tag;
  logic [XLEN-1:0]      win_value;

  // Ready comes from the registered count only, so a full buffer never passes through.
  // Tag 0 completes the handshake but is never stored.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i]    = (count_q[i] != Full);
      nonempty[i] = (count_q[i] != '0);
      push[i]     = bus.fu_valid[i] && ready[i] && !squash &&
                    (bus.fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W] != '0);
    end
  end

  // Round-robin scan starting at rr_q, wrapping modulo NUM_FU.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      int unsigned j;
      j = (32'(rr_q) + 32'(k)) % NUM_FU;
      if (!found && nonempty[j]) begin
        found = 1'b1;
        win   = IdxW'(j);
      end
    end
  end

  always_comb begin
    pop       = '0;
    win_tag   = '0;
    win_value = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (found && (win == IdxW'(i))) begin
        pop[i]    = 1'b1;
        win_tag   = tag_mem_q[i][head_q[i]];
        win_value = val_mem_q[i][head_q[i]];
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_idx_d   = cdb_idx_q;
    for (int i = 0; i < NUM_FU; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
    end

    if (squash) begin
      rr_d        = '0;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = '0;
      cdb_value_d = '0;
      cdb_idx_d   = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      for (int i = 0; i < NUM_FU; i++) begin
        head_d[i]  = head_q[i] + PtrW'(pop[i]);
        tail_d[i]  = tail_q[i] + PtrW'(push[i]);
        count_d[i] = count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      if (found) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = win_tag;
        cdb_value_d = win_value;
        cdb_idx_d   = win;
        rr_d        = (win == IdxW'(NUM_FU - 1)) ? '0 : win + IdxW'(1);
      end else begin
        // Idle tag must be zero so no reservation station can match.
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_idx_q   <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_idx_q   <= cdb_idx_d;
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // Storage needs no reset: entries are only read when count marks them live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem_q[i][tail_q[i]] <= bus.fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
        val_mem_q[i][tail_q[i]] <= bus.fu_value[i*XLEN +: XLEN];
      end
    end
  end

  assign bus.fu_ready    = ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_tag = cdb_tag_q;
  assign bus.cdb_value   = cdb_value_q;
  assign bus.cdb_fu_idx  = cdb_idx_q;

`ifdef CDB_STATS_EN
  logic [31:0] bcast_q, stall_q;
  logic        stall;

  assign stall = |(bus.fu_valid & ~ready);

  // Not cleared by squash; saturate at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcast_q <= '0;
      stall_q <= '0;
    end else begin
      if (found && !squash && (bcast_q != '1)) bcast_q <= bcast_q + 32'd1;
      if (stall && (stall_q != '1))            stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_broadcasts   = bcast_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int unsigned NFU   = 5;
  localparam int unsigned TW    = 5;
  localparam int unsigned XW    = 32;
  localparam int unsigned DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash = 1'b0;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(NFU), .ROB_TAG_W(TW), .XLEN(XW)) bus ();

`ifdef CDB_STATS_EN
  logic [31:0] stat_b, stat_s;
`endif

  cdb_arbiter #(
    .NUM_FU    (NFU),
    .ROB_TAG_W (TW),
    .XLEN      (XW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .bus   (bus)
`ifdef CDB_STATS_EN
    ,
    .stat_broadcasts  (stat_b),
    .stat_stall_cycles(stat_s)
`endif
  );

  // ---------------- behavioural model: per-FU queues + rotating priority ----------------
  typedef struct {
    logic [TW-1:0] tag;
    logic [XW-1:0] val;
  } ent_t;

  ent_t          mq [NFU][$];
  int            m_rr;
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [XW-1:0] m_val;
  int            m_idx;
  logic [NFU-1:0] acc_last;
  logic [31:0]   m_bc, m_st;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NFU-1:0] m_ready();
    logic [NFU-1:0] r;
    for (int i = 0; i < NFU; i++) r[i] = (mq[i].size() != DEPTH);
    return r;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NFU; i++) mq[i].delete();
    m_rr = 0; m_valid = 1'b0; m_tag = '0; m_val = '0; m_idx = 0;
  endtask

  task automatic model_clear();
    model_flush();
    acc_last = '0; m_bc = '0; m_st = '0;
  endtask

  // What happens at one rising edge, given the inputs presented during the cycle.
  task automatic model_edge();
    logic [NFU-1:0] rdy;
    int win;
    ent_t e;
    logic [TW-1:0] t;
    if (reset) begin
      model_clear();
      return;
    end
    rdy = m_ready();
    if (((bus.fu_valid & ~rdy) != '0) && (m_st != 32'hFFFF_FFFF)) m_st++;
    acc_last = bus.fu_valid & rdy;
    if (squash) begin
      model_flush();
      return;
    end
    win = -1;
    for (int k = 0; k < NFU; k++) begin
      int j;
      j = (m_rr + k) % NFU;
      if (win < 0 && mq[j].size() > 0) win = j;
    end
    if (win >= 0) begin
      e = mq[win].pop_front();
      m_valid = 1'b1; m_tag = e.tag; m_val = e.val; m_idx = win;
      m_rr = (win + 1) % NFU;
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
    end else begin
      m_valid = 1'b0; m_tag = '0; m_val = '0;
    end
    for (int i = 0; i < NFU; i++) begin
      t = bus.fu_rob_tag[i*TW +: TW];
      if (acc_last[i] && t != '0) begin
        e.tag = t;
        e.val = bus.fu_value[i*XW +: XW];
        mq[i].push_back(e);
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      chk("cdb_rob_tag", 64'(bus.cdb_rob_tag), 64'(m_tag));
      chk("cdb_value", 64'(bus.cdb_value), 64'(m_val));
      chk("fu_ready", 64'(bus.fu_ready), 64'(m_ready()));
      if (m_valid) chk("cdb_fu_idx", 64'(bus.cdb_fu_idx), 64'(m_idx));
`ifdef CDB_STATS_EN
      chk("stat_broadcasts", 64'(stat_b), 64'(m_bc));
      chk("stat_stall_cycles", 64'(stat_s), 64'(m_st));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TW-1:0] t,
                        input logic [XW-1:0] val);
    bus.fu_valid[i]           = v;
    bus.fu_rob_tag[i*TW +: TW] = t;
    bus.fu_value[i*XW +: XW]   = val;
  endtask

  task automatic idle_all();
    bus.fu_valid   = '0;
    bus.fu_rob_tag = '0;
    bus.fu_value   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    model_clear();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    int s0, bp3, n0, rate;
    logic [TW-1:0] seen3 [$];

    idle_all();
    model_clear();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_valid", 64'(bus.cdb_valid), 64'd0);
      chk("idle_tag", 64'(bus.cdb_rob_tag), 64'd0);
      chk("idle_ready", 64'(bus.fu_ready), 64'h1f);
    end

    // Single result: accepted at E1, visible two cycles later, then gone.
    set_fu(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    idle_all();
    chk("single_lat1", 64'(bus.cdb_valid), 64'd0);
    tick();
    chk("single_valid", 64'(bus.cdb_valid), 64'd1);
    chk("single_tag", 64'(bus.cdb_rob_tag), 64'd3);
    chk("single_value", 64'(bus.cdb_value), 64'hDEAD_BEEF);
    chk("single_idx", 64'(bus.cdb_fu_idx), 64'd0);
    tick();
    chk("single_after", 64'(bus.cdb_valid), 64'd0);

    // All five at once, from a fresh pointer.
    do_reset();
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, TW'(i + 1), 32'hA000 + 32'(i));
    tick();
    idle_all();
    for (int k = 0; k < NFU; k++) begin
      tick();
      chk("all5_valid", 64'(bus.cdb_valid), 64'd1);
      chk("all5_idx", 64'(bus.cdb_fu_idx), 64'(k));
      chk("all5_tag", 64'(bus.cdb_rob_tag), 64'(k + 1));
    end
    // Pointer back at 0: FU1 must beat FU4.
    set_fu(1, 1'b1, 5'd20, 32'h1);
    set_fu(4, 1'b1, 5'd21, 32'h4);
    tick();
    idle_all();
    tick();
    chk("rr0_first", 64'(bus.cdb_fu_idx), 64'd1);
    tick();
    chk("rr0_second", 64'(bus.cdb_fu_idx), 64'd4);

    // Backpressure: FU3 sends 7,8,9 back to back while FU0 streams.
    do_reset();
    s0 = 0; bp3 = 0; n0 = 0;
    for (int c = 0; c < 30; c++) begin
      if (s0 < 10) set_fu(0, 1'b1, TW'(10 + s0), 32'h1000 + 32'(s0));
      else         set_fu(0, 1'b0, '0, '0);
      if (bp3 < 3) set_fu(3, 1'b1, TW'(7 + bp3), 32'h300 + 32'(bp3));
      else         set_fu(3, 1'b0, '0, '0);
      tick();
      if (acc_last[0]) s0++;
      if (acc_last[3]) bp3++;
      if (c == 1) chk("bp_ready3_low", 64'(bus.fu_ready[3]), 64'd0);
      if (bus.cdb_valid && bus.cdb_fu_idx == 3'd3) seen3.push_back(bus.cdb_rob_tag);
      if (bus.cdb_valid && bus.cdb_fu_idx == 3'd0) n0++;
    end
    chk("bp_fu3_count", 64'(seen3.size()), 64'd3);
    if (seen3.size() == 3)
      for (int k = 0; k < 3; k++) chk("bp_fu3_order", 64'(seen3[k]), 64'(7 + k));
    chk("bp_fu0_count", 64'(n0), 64'd10);

    // Tag 0 handshakes but never broadcasts.
    set_fu(1, 1'b1, 5'd0, 32'h55);
    chk("tag0_ready", 64'(bus.fu_ready[1]), 64'd1);
    tick();
    idle_all();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("tag0_nobcast", 64'(bus.cdb_valid), 64'd0);
    end

    // Squash with one on the bus and two buffered.
    do_reset();
    set_fu(0, 1'b1, 5'd11, 32'hB0);
    set_fu(1, 1'b1, 5'd12, 32'hB1);
    set_fu(2, 1'b1, 5'd13, 32'hB2);
    tick();
    idle_all();
    tick();
    chk("sq_pre_valid", 64'(bus.cdb_valid), 64'd1);
    chk("sq_pre_tag", 64'(bus.cdb_rob_tag), 64'd11);
`ifdef CDB_STATS_EN
    chk("sq_pre_stat", 64'(stat_b), 64'd1);
`endif
    squash = 1'b1;
    set_fu(3, 1'b1, 5'd14, 32'hB3);
    tick();
    squash = 1'b0;
    idle_all();
    chk("sq_valid", 64'(bus.cdb_valid), 64'd0);
    chk("sq_tag", 64'(bus.cdb_rob_tag), 64'd0);
    chk("sq_ready", 64'(bus.fu_ready), 64'h1f);
`ifdef CDB_STATS_EN
    chk("sq_stat_kept", 64'(stat_b), 64'd1);
`endif
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("sq_nothing", 64'(bus.cdb_valid), 64'd0);
    end

    // Randomized traffic with occasional squash and reset.
    rate = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rate = 30 + int'($urandom_range(0, 65));
      if ($urandom_range(0, 999) == 0) do_reset();
      squash = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NFU; i++) begin
        if (!(bus.fu_valid[i] && !acc_last[i])) begin
          if (int'($urandom_range(0, 99)) < rate)
            set_fu(i, 1'b1, TW'($urandom_range(0, 31)), $urandom);
          else
            set_fu(i, 1'b0, '0, '0);
        end
      end
      tick();
    end
    squash = 1'b0;
    idle_all();
    for (int c = 0; c < 12; c++) tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
